// File: rtl/jedro_1_csr_irq.sv
// jedro_1 machine-mode CSR file with trap and interrupt control.
// Vectored mtvec, platform-local IRQ lines, wide cycle/instret counters.

module jedro_1_csr_irq #(
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned COUNTER_W     = 64,
  parameter logic [31:0] BOOT_MTVEC    = 32'h0040_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     csr_we_i,
  input  logic                     csr_re_i,
  input  logic [11:0]              csr_addr_i,
  input  logic [31:0]              csr_wdata_i,
  input  logic [1:0]               csr_wmode_i,
  output logic [31:0]              csr_rdata_o,
  output logic                     csr_illegal_o,
  input  logic                     irq_ext_i,
  input  logic                     irq_timer_i,
  input  logic                     irq_sw_i,
  input  logic [NUM_LOCAL_IRQ-1:0] irq_local_i,
  output logic                     irq_req_o,
  input  logic                     irq_ack_i,
  input  logic                     exc_i,
  input  logic [4:0]               exc_cause_i,
  input  logic [31:0]              exc_tval_i,
  input  logic [31:0]              trap_pc_i,
  input  logic                     mret_i,
  input  logic                     instret_i,
  output logic                     redirect_o,
  output logic [31:0]              redirect_addr_o
);

  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK =
    32'h0000_0888 | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);
  localparam logic        HAS_HI   = (COUNTER_W > 32);

  logic                 r_mstat_mie;
  logic                 r_mpie;
  logic [31:0]          r_mie;
  logic [31:0]          r_mip;
  logic [31:0]          r_mtvec;
  logic [31:0]          r_mscratch;
  logic [31:0]          r_mepc;
  logic [31:0]          r_mcause;
  logic [31:0]          r_mtval;
  logic [COUNTER_W-1:0] r_cyc;
  logic [COUNTER_W-1:0] r_ins;
  logic                 r_redirect;
  logic [31:0]          r_raddr;

  logic [63:0] w_cyc64;
  logic [63:0] w_ins64;
  logic [63:0] w_cyc_wr;
  logic [63:0] w_ins_wr;
  logic [31:0] w_rdata;
  logic        w_impl;
  logic        w_ro;
  logic [31:0] w_wval;
  logic        w_wr;
  logic [31:0] w_pend;
  logic [4:0]  w_irq_code;
  logic        w_take_irq;
  logic        w_trap;
  logic [4:0]  w_code;
  logic [31:0] w_base;
  logic [31:0] w_tvec;
  logic [31:0] w_mip_in;
  logic        w_cyc_lo_we;
  logic        w_cyc_hi_we;
  logic        w_ins_lo_we;
  logic        w_ins_hi_we;

  assign w_cyc64 = 64'(r_cyc);
  assign w_ins64 = 64'(r_ins);

  always_comb begin
    w_rdata = 32'b0;
    w_impl  = 1'b1;
    w_ro    = 1'b0;
    unique case (csr_addr_i)
      A_MVENDORID, A_MARCHID,
      A_MIMPID, A_MHARTID: w_ro = 1'b1;
      A_MISA: begin
        w_rdata = MISA_VAL;
        w_ro    = 1'b1;
      end
      A_MSTATUS:   w_rdata = {24'b0, r_mpie, 3'b0, r_mstat_mie, 3'b0};
      A_MIE:       w_rdata = r_mie;
      A_MIP:       w_rdata = r_mip;
      A_MTVEC:     w_rdata = r_mtvec;
      A_MSCRATCH:  w_rdata = r_mscratch;
      A_MEPC:      w_rdata = r_mepc;
      A_MCAUSE:    w_rdata = r_mcause;
      A_MTVAL:     w_rdata = r_mtval;
      A_MCYCLE:    w_rdata = w_cyc64[31:0];
      A_MCYCLEH:   w_rdata = w_cyc64[63:32];
      A_MINSTRET:  w_rdata = w_ins64[31:0];
      A_MINSTRETH: w_rdata = w_ins64[63:32];
      default:     w_impl  = 1'b0;
    endcase
  end

  assign csr_rdata_o   = w_rdata;
  assign csr_illegal_o = (csr_we_i | csr_re_i) &
                         (~w_impl | (csr_we_i & w_ro));

  always_comb begin
    w_wval = csr_wdata_i;
    unique case (csr_wmode_i)
      2'b01:   w_wval = w_rdata | csr_wdata_i;
      2'b10:   w_wval = w_rdata & ~csr_wdata_i;
      default: w_wval = csr_wdata_i;
    endcase
  end

  assign w_pend    = r_mip & r_mie;
  assign irq_req_o = r_mstat_mie & (|w_pend);

  // Later assignments override earlier ones: lowest priority first.
  always_comb begin
    w_irq_code = 5'd0;
    for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--) begin
      if (w_pend[16+i]) w_irq_code = 5'(16 + i);
    end
    if (w_pend[7])  w_irq_code = 5'd7;
    if (w_pend[3])  w_irq_code = 5'd3;
    if (w_pend[11]) w_irq_code = 5'd11;
  end

  assign w_take_irq = irq_ack_i & irq_req_o & ~exc_i;
  assign w_trap     = exc_i | w_take_irq;
  assign w_code     = w_take_irq ? w_irq_code : exc_cause_i;
  assign w_base     = {r_mtvec[31:2], 2'b00};
  assign w_tvec     = (w_take_irq && r_mtvec[1:0] == 2'b01) ?
                      w_base + {25'b0, w_code, 2'b00} : w_base;
  assign w_wr       = csr_we_i & ~csr_illegal_o & ~w_trap & ~mret_i;

  assign w_mip_in = (32'(irq_local_i) << 16) |
                    {20'b0, irq_ext_i, 3'b0, irq_timer_i,
                     3'b0, irq_sw_i, 3'b0};

  assign w_cyc_lo_we = w_wr & (csr_addr_i == A_MCYCLE);
  assign w_cyc_hi_we = w_wr & (csr_addr_i == A_MCYCLEH) & HAS_HI;
  assign w_ins_lo_we = w_wr & (csr_addr_i == A_MINSTRET);
  assign w_ins_hi_we = w_wr & (csr_addr_i == A_MINSTRETH) & HAS_HI;

  assign w_cyc_wr = {w_cyc_hi_we ? w_wval : w_cyc64[63:32],
                     w_cyc_lo_we ? w_wval : w_cyc64[31:0]};
  assign w_ins_wr = {w_ins_hi_we ? w_wval : w_ins64[63:32],
                     w_ins_lo_we ? w_wval : w_ins64[31:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mstat_mie <= 1'b0;
      r_mpie      <= 1'b0;
      r_mie       <= 32'b0;
      r_mip       <= 32'b0;
      r_mtvec     <= BOOT_MTVEC;
      r_mscratch  <= 32'b0;
      r_mepc      <= 32'b0;
      r_mcause    <= 32'b0;
      r_mtval     <= 32'b0;
    end else begin
      r_mip <= w_mip_in;
      if (w_trap) begin
        r_mepc      <= trap_pc_i & 32'hFFFF_FFFC;
        r_mcause    <= {w_take_irq, 26'b0, w_code};
        r_mtval     <= w_take_irq ? 32'b0 : exc_tval_i;
        r_mpie      <= r_mstat_mie;
        r_mstat_mie <= 1'b0;
      end else if (mret_i) begin
        r_mstat_mie <= r_mpie;
        r_mpie      <= 1'b1;
      end else if (w_wr) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            r_mstat_mie <= w_wval[3];
            r_mpie      <= w_wval[7];
          end
          A_MIE:      r_mie      <= w_wval & MIE_MASK;
          // Reserved mode encodings keep the previous mode.
          A_MTVEC:    r_mtvec    <= {w_wval[31:2],
                                     w_wval[1] ? r_mtvec[1:0] : w_wval[1:0]};
          A_MSCRATCH: r_mscratch <= w_wval;
          A_MEPC:     r_mepc     <= w_wval & 32'hFFFF_FFFC;
          A_MCAUSE:   r_mcause   <= w_wval;
          A_MTVAL:    r_mtval    <= w_wval;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      if (w_cyc_lo_we | w_cyc_hi_we) r_cyc <= w_cyc_wr[COUNTER_W-1:0];
      else                           r_cyc <= r_cyc + COUNTER_W'(1);
      if (w_ins_lo_we | w_ins_hi_we) r_ins <= w_ins_wr[COUNTER_W-1:0];
      else if (instret_i)            r_ins <= r_ins + COUNTER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_redirect <= 1'b0;
      r_raddr    <= 32'b0;
    end else begin
      r_redirect <= w_trap | mret_i;
      if (w_trap)      r_raddr <= w_tvec;
      else if (mret_i) r_raddr <= r_mepc;
    end
  end

  assign redirect_o      = r_redirect;
  assign redirect_addr_o = r_raddr;

endmodule

// File: tb/tb_jedro_1_csr_irq.sv
// Bench for jedro_1_csr_irq: directed vector table plus random
// stimulus against a rule-level reference model.

module tb_jedro_1_csr_irq;

  localparam int NL = 4;
  localparam int CW = 64;

  localparam int C_RD = 1;
  localparam int C_IL = 2;
  localparam int C_RQ = 4;
  localparam int C_RV = 8;
  localparam int C_RA = 16;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wmode;
    logic        ext;
    logic        tmr;
    logic        sw;
    logic [3:0]  loc;
    logic        ack;
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [31:0] pc;
    logic        mret;
    logic        ins;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          mask;
    logic [31:0] rd;
    logic        il;
    logic        rq;
    logic        rv;
    logic [31:0] ra;
  } vec_t;

  logic          clk;
  logic          rst_i;
  logic          csr_we_i;
  logic          csr_re_i;
  logic [11:0]   csr_addr_i;
  logic [31:0]   csr_wdata_i;
  logic [1:0]    csr_wmode_i;
  logic [31:0]   csr_rdata_o;
  logic          csr_illegal_o;
  logic          irq_ext_i;
  logic          irq_timer_i;
  logic          irq_sw_i;
  logic [NL-1:0] irq_local_i;
  logic          irq_req_o;
  logic          irq_ack_i;
  logic          exc_i;
  logic [4:0]    exc_cause_i;
  logic [31:0]   exc_tval_i;
  logic [31:0]   trap_pc_i;
  logic          mret_i;
  logic          instret_i;
  logic          redirect_o;
  logic [31:0]   redirect_addr_o;

  int n_vec = 0;
  int n_err = 0;

  jedro_1_csr_irq #(
    .NUM_LOCAL_IRQ(NL),
    .COUNTER_W(CW),
    .BOOT_MTVEC(32'h0040_0000)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .csr_we_i(csr_we_i),
    .csr_re_i(csr_re_i),
    .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i),
    .csr_wmode_i(csr_wmode_i),
    .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o),
    .irq_ext_i(irq_ext_i),
    .irq_timer_i(irq_timer_i),
    .irq_sw_i(irq_sw_i),
    .irq_local_i(irq_local_i),
    .irq_req_o(irq_req_o),
    .irq_ack_i(irq_ack_i),
    .exc_i(exc_i),
    .exc_cause_i(exc_cause_i),
    .exc_tval_i(exc_tval_i),
    .trap_pc_i(trap_pc_i),
    .mret_i(mret_i),
    .instret_i(instret_i),
    .redirect_o(redirect_o),
    .redirect_addr_o(redirect_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mstat, mie, mip, mtvec, mscr, mepc, mcause, mtval;
  logic [63:0] cyc, ins, cmask;
  logic        m_rv;
  logic [31:0] m_ra;

  task automatic m_reset();
    mstat = 0; mie = 0; mip = 0; mtvec = 32'h0040_0000;
    mscr = 0; mepc = 0; mcause = 0; mtval = 0;
    cyc = 0; ins = 0; m_rv = 0; m_ra = 0;
  endtask

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return mstat;
      12'h301: return 32'h4000_0100;
      12'h304: return mie;
      12'h305: return mtvec;
      12'h340: return mscr;
      12'h341: return mepc;
      12'h342: return mcause;
      12'h343: return mtval;
      12'h344: return mip;
      12'hB00: return cyc[31:0];
      12'hB80: return cyc[63:32];
      12'hB02: return ins[31:0];
      12'hB82: return ins[63:32];
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic m_ill(stim_t s);
    logic impl, ro;
    impl = s.addr inside {12'hF11, 12'hF12, 12'hF13, 12'hF14,
                          12'h300, 12'h301, 12'h304, 12'h305,
                          12'h340, 12'h341, 12'h342, 12'h343,
                          12'h344, 12'hB00, 12'hB80, 12'hB02,
                          12'hB82};
    ro = s.addr inside {12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h301};
    return (s.we || s.re) && (!impl || (s.we && ro));
  endfunction

  function automatic logic m_req();
    return mstat[3] && ((mip & mie) != 0);
  endfunction

  function automatic int m_pick(logic [31:0] p);
    int ord[$];
    ord = {11, 3, 7};
    for (int i = 0; i < NL; i++) ord.push_back(16 + i);
    foreach (ord[k]) if (p[ord[k]]) return ord[k];
    return 0;
  endfunction

  task automatic m_step(stim_t s);
    logic [31:0] old, nv, wmask, base;
    logic        irq, trap, wr;
    logic [63:0] cn, inn;
    int          code;
    if (s.rst) begin
      m_reset();
      return;
    end
    irq  = s.ack && m_req() && !s.exc;
    trap = s.exc || irq;
    wr   = s.we && !m_ill(s) && !trap && !s.mret;
    old  = m_read(s.addr);
    nv   = (s.wmode == 2'd1) ? (old | s.wdata) :
           (s.wmode == 2'd2) ? (old & ~s.wdata) : s.wdata;
    wmask = 32'h888;
    for (int i = 0; i < NL; i++) wmask[16+i] = 1'b1;
    cn  = (cyc + 64'd1) & cmask;
    inn = s.ins ? ((ins + 64'd1) & cmask) : ins;
    if (wr) begin
      case (s.addr)
        12'h300: mstat = nv & 32'h88;
        12'h304: mie = nv & wmask;
        12'h305: mtvec = {nv[31:2], nv[1] ? mtvec[1:0] : nv[1:0]};
        12'h340: mscr = nv;
        12'h341: mepc = nv & ~32'h3;
        12'h342: mcause = nv;
        12'h343: mtval = nv;
        12'hB00: cn = ((cyc & 64'hFFFF_FFFF_0000_0000) | 64'(nv)) & cmask;
        12'hB02: inn = ((ins & 64'hFFFF_FFFF_0000_0000) | 64'(nv)) & cmask;
        12'hB80: if (CW > 32) cn = ((64'(nv) << 32) | (cyc & 64'hFFFF_FFFF)) & cmask;
        12'hB82: if (CW > 32) inn = ((64'(nv) << 32) | (ins & 64'hFFFF_FFFF)) & cmask;
        default: ;
      endcase
    end
    cyc = cn;
    ins = inn;
    m_rv = trap || s.mret;
    if (trap) begin
      code   = irq ? m_pick(mip & mie) : int'(s.cause);
      base   = mtvec & ~32'h3;
      m_ra   = (irq && mtvec[1:0] == 2'b01) ? base + 32'(4 * code) : base;
      mepc   = s.pc & ~32'h3;
      mcause = {irq, 26'b0, 5'(code)};
      mtval  = irq ? 32'b0 : s.tval;
      mstat  = mstat[3] ? 32'h80 : 32'h0;
    end else if (s.mret) begin
      m_ra  = mepc;
      mstat = 32'h80 | (mstat[7] ? 32'h8 : 32'h0);
    end
    mip = 0;
    mip[11] = s.ext;
    mip[7]  = s.tmr;
    mip[3]  = s.sw;
    for (int i = 0; i < NL; i++) mip[16+i] = s.loc[i];
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(stim_t s);
    rst_i       = s.rst;
    csr_we_i    = s.we;
    csr_re_i    = s.re;
    csr_addr_i  = s.addr;
    csr_wdata_i = s.wdata;
    csr_wmode_i = s.wmode;
    irq_ext_i   = s.ext;
    irq_timer_i = s.tmr;
    irq_sw_i    = s.sw;
    irq_local_i = s.loc;
    irq_ack_i   = s.ack;
    exc_i       = s.exc;
    exc_cause_i = s.cause;
    exc_tval_i  = s.tval;
    trap_pc_i   = s.pc;
    mret_i      = s.mret;
    instret_i   = s.ins;
  endtask

  task automatic run(vec_t v);
    @(negedge clk);
    drive(v.s);
    #1;
    chk("rdata_model", csr_rdata_o, m_read(v.s.addr));
    chk("illegal_model", 32'(csr_illegal_o), 32'(m_ill(v.s)));
    chk("irq_req_model", 32'(irq_req_o), 32'(m_req()));
    chk("redirect_model", 32'(redirect_o), 32'(m_rv));
    if (m_rv) chk("raddr_model", redirect_addr_o, m_ra);
    if ((v.mask & C_RD) != 0) chk("rdata_tbl", csr_rdata_o, v.rd);
    if ((v.mask & C_IL) != 0) chk("illegal_tbl", 32'(csr_illegal_o), 32'(v.il));
    if ((v.mask & C_RQ) != 0) chk("irq_req_tbl", 32'(irq_req_o), 32'(v.rq));
    if ((v.mask & C_RV) != 0) chk("redirect_tbl", 32'(redirect_o), 32'(v.rv));
    if ((v.mask & C_RA) != 0) chk("raddr_tbl", redirect_addr_o, v.ra);
    m_step(v.s);
  endtask

  vec_t tbl[$];

  task automatic add(stim_t s, int m, logic [31:0] rd, logic il,
                     logic rq, logic rv, logic [31:0] ra);
    vec_t v;
    v.s = s; v.mask = m; v.rd = rd; v.il = il;
    v.rq = rq; v.rv = rv; v.ra = ra;
    tbl.push_back(v);
  endtask

  function automatic stim_t rd(logic [11:0] a);
    stim_t s = '0;
    s.re = 1'b1;
    s.addr = a;
    return s;
  endfunction

  function automatic stim_t wr(logic [11:0] a, logic [31:0] d, logic [1:0] m);
    stim_t s = '0;
    s.we = 1'b1;
    s.addr = a;
    s.wdata = d;
    s.wmode = m;
    return s;
  endfunction

  logic [11:0] alist [16] = '{12'h300, 12'h301, 12'h304, 12'h305,
                             12'h340, 12'h341, 12'h342, 12'h343,
                             12'h344, 12'hF11, 12'hF14, 12'hB00,
                             12'hB80, 12'hB02, 12'hB82, 12'h7C0};

  initial begin
    stim_t s;
    vec_t  v;
    int    idx;
    cmask = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
    s = '0;
    s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    m_reset();

    s = '0; s.rst = 1'b1;
    add(s, C_IL | C_RQ | C_RV, 0, 0, 0, 0, 0);
    add(s, C_IL | C_RQ | C_RV, 0, 0, 0, 0, 0);
    add(rd(12'h305), C_RD | C_IL, 32'h0040_0000, 0, 0, 0, 0);
    add(rd(12'h301), C_RD | C_IL, 32'h4000_0100, 0, 0, 0, 0);
    add(rd(12'h7C0), C_RD | C_IL, 32'h0, 1, 0, 0, 0);
    add(wr(12'h304, 32'h808, 2'd0), C_IL, 0, 0, 0, 0, 0);
    add(wr(12'h300, 32'h8, 2'd0), 0, 0, 0, 0, 0, 0);
    s = '0; s.tmr = 1; s.ext = 1;
    add(s, C_RQ, 0, 0, 0, 0, 0);
    s = '0; s.ack = 1; s.pc = 32'h100;
    add(s, C_RQ, 0, 0, 1, 0, 0);
    add(rd(12'h342), C_RD | C_RQ | C_RV | C_RA, 32'h8000_000B, 0, 0, 1, 32'h0040_0000);
    add(rd(12'h341), C_RD | C_RV, 32'h100, 0, 0, 0, 0);
    add(rd(12'h300), C_RD, 32'h80, 0, 0, 0, 0);
    add(wr(12'h305, 32'h0040_0001, 2'd0), 0, 0, 0, 0, 0, 0);
    add(wr(12'h304, 32'h0004_0000, 2'd1), 0, 0, 0, 0, 0, 0);
    add(wr(12'h300, 32'h8, 2'd1), 0, 0, 0, 0, 0, 0);
    s = '0; s.loc = 4'b0100;
    add(s, C_RQ, 0, 0, 0, 0, 0);
    s.ack = 1; s.pc = 32'h100;
    add(s, C_RQ, 0, 0, 1, 0, 0);
    s = '0; s.loc = 4'b0100;
    add(s, C_RQ | C_RV | C_RA, 0, 0, 0, 1, 32'h0040_0048);
    s.mret = 1;
    add(s, 0, 0, 0, 0, 0, 0);
    s = rd(12'h300); s.loc = 4'b0100;
    add(s, C_RD | C_RQ | C_RV | C_RA, 32'h88, 0, 1, 1, 32'h100);
    s = wr(12'h340, 32'h1234, 2'd0); s.loc = 4'b0100;
    s.exc = 1; s.cause = 5'd2; s.tval = 32'hDEAD; s.ack = 1; s.pc = 32'h300;
    add(s, C_RQ, 0, 0, 1, 0, 0);
    s = rd(12'h342); s.loc = 4'b0100;
    add(s, C_RD | C_RQ | C_RV | C_RA, 32'h2, 0, 0, 1, 32'h0040_0000);
    s = rd(12'h343); s.loc = 4'b0100;
    add(s, C_RD, 32'hDEAD, 0, 0, 0, 0);
    s = rd(12'h340); s.loc = 4'b0100;
    add(s, C_RD, 32'h0, 0, 0, 0, 0);
    s = '0; s.loc = 4'b0100; s.mret = 1;
    add(s, 0, 0, 0, 0, 0, 0);
    s = rd(12'h300); s.loc = 4'b0100;
    add(s, C_RD | C_RQ | C_RV | C_RA, 32'h88, 0, 1, 1, 32'h300);
    add('0, 0, 0, 0, 0, 0, 0);
    add(wr(12'hB00, 32'hFFFF_FFFF, 2'd0), 0, 0, 0, 0, 0, 0);
    add(wr(12'hB80, 32'hFFFF_FFFF, 2'd0), 0, 0, 0, 0, 0, 0);
    add(rd(12'hB00), C_RD, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add(rd(12'hB00), C_RD, 32'h0, 0, 0, 0, 0);
    add(rd(12'hB80), C_RD, 32'h0, 0, 0, 0, 0);
    s = wr(12'hB02, 32'h5, 2'd0); s.ins = 1;
    add(s, 0, 0, 0, 0, 0, 0);
    add(rd(12'hB02), C_RD, 32'h5, 0, 0, 0, 0);
    add(wr(12'h305, 32'h0040_0002, 2'd0), 0, 0, 0, 0, 0, 0);
    add(rd(12'h305), C_RD, 32'h0040_0001, 0, 0, 0, 0);
    add(wr(12'h340, 32'hF0, 2'd0), 0, 0, 0, 0, 0, 0);
    add(wr(12'h340, 32'h0F, 2'd1), 0, 0, 0, 0, 0, 0);
    add(rd(12'h340), C_RD, 32'hFF, 0, 0, 0, 0);
    add(wr(12'h340, 32'hF0, 2'd2), 0, 0, 0, 0, 0, 0);
    add(rd(12'h340), C_RD, 32'h0F, 0, 0, 0, 0);
    add(wr(12'hF14, 32'h1, 2'd0), C_IL, 0, 1, 0, 0, 0);
    add(wr(12'h344, 32'hFFFF_FFFF, 2'd0), C_IL, 0, 0, 0, 0, 0);
    add(rd(12'h344), C_RD | C_IL, 32'h0, 0, 0, 0, 0);
    add(wr(12'h341, 32'h103, 2'd0), 0, 0, 0, 0, 0, 0);
    add(rd(12'h341), C_RD, 32'h100, 0, 0, 0, 0);
    s = '0; s.ack = 1; s.pc = 32'h700;
    add(s, C_RQ, 0, 0, 0, 0, 0);
    add('0, C_RV, 0, 0, 0, 0, 0);
    s = '0; s.exc = 1; s.cause = 5'd3; s.mret = 1; s.pc = 32'h500;
    add(s, 0, 0, 0, 0, 0, 0);
    add(rd(12'h342), C_RD | C_RV | C_RA, 32'h3, 0, 0, 1, 32'h0040_0000);
    add(rd(12'h341), C_RD, 32'h500, 0, 0, 0, 0);
    add(rd(12'h300), C_RD, 32'h80, 0, 0, 0, 0);
    s = '0; s.exc = 1; s.cause = 5'd5; s.pc = 32'h40;
    add(s, 0, 0, 0, 0, 0, 0);
    s = '0; s.rst = 1;
    add(s, C_RV, 0, 0, 0, 1, 0);
    add(rd(12'h342), C_RD | C_RV, 32'h0, 0, 0, 0, 0);
    add(rd(12'h305), C_RD, 32'h0040_0000, 0, 0, 0, 0);
    add(rd(12'h300), C_RD, 32'h0, 0, 0, 0, 0);

    foreach (tbl[k]) run(tbl[k]);

    for (int n = 0; n < 3000; n++) begin
      s = '0;
      s.rst   = ($urandom_range(0, 149) == 0);
      s.we    = ($urandom_range(0, 9) < 3);
      s.re    = ($urandom_range(0, 1) == 1);
      idx     = int'($urandom_range(0, 16));
      s.addr  = (idx == 16) ? 12'($urandom) : alist[idx];
      s.wdata = $urandom;
      s.wmode = 2'($urandom_range(0, 2));
      s.ext   = ($urandom_range(0, 9) < 2);
      s.tmr   = ($urandom_range(0, 9) < 2);
      s.sw    = ($urandom_range(0, 9) < 2);
      s.loc   = 4'($urandom) & 4'($urandom);
      s.ack   = ($urandom_range(0, 3) == 0);
      s.exc   = ($urandom_range(0, 24) == 0);
      s.cause = 5'($urandom);
      s.tval  = $urandom;
      s.pc    = $urandom;
      s.mret  = ($urandom_range(0, 24) == 0);
      s.ins   = ($urandom_range(0, 1) == 1);
      v.s = s; v.mask = 0; v.rd = 0; v.il = 0;
      v.rq = 0; v.rv = 0; v.ra = 0;
      run(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
